// File: rtl/cmp_pipe.sv
// rtl/cmp_pipe.sv - two-stage handshaked magnitude/equality comparator
// S1 registers operands, S2 registers the compare result; ready/valid on both sides.
module cmp_pipe #(
  parameter int WIDTH     = 16,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             compout,
  output logic [2:0]       flags,
  output logic             sel_err
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_sel;

  logic             s2_valid;
  logic             s2_comp;
  logic [2:0]       s2_flags;
  logic             s2_err;

  logic             s1_adv;
  logic             accept;
  logic             eq;
  logic             lt_u;
  logic             lt_s;
  logic             lt;
  logic             comp_nxt;
  logic             err_nxt;

  // S1 may move into S2 when S2 is empty or is being emptied at this same edge.
  assign s1_adv   = s1_valid && (!s2_valid || out_ready);
  assign in_ready = rst_n && (!s1_valid || s1_adv);
  assign accept   = in_valid && in_ready;

  always_comb begin
    eq       = (s1_a == s1_b);
    lt_u     = (s1_a < s1_b);
    lt_s     = ($signed(s1_a) < $signed(s1_b));
    lt       = ((SIGNED_EN != 0) && s1_sel[3]) ? lt_s : lt_u;
    comp_nxt = 1'b0;
    err_nxt  = 1'b0;
    case (s1_sel[2:0])
      3'd0:    comp_nxt = eq;
      3'd1:    comp_nxt = !eq;
      3'd2:    comp_nxt = !lt && !eq;
      3'd3:    comp_nxt = !lt;
      3'd4:    comp_nxt = lt;
      3'd5:    comp_nxt = lt || eq;
      default: err_nxt  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Operand registers carry no reset; their contents only matter while s1_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a   <= a;
      s1_b   <= b;
      s1_sel <= sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_comp  <= 1'b0;
      s2_flags <= 3'b000;
      s2_err   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_comp  <= comp_nxt;
      s2_flags <= {lt_s, lt_u, eq};
      s2_err   <= err_nxt;
    end else if (s2_valid && out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign compout   = s2_comp;
  assign flags     = s2_flags;
  assign sel_err   = s2_err;

endmodule

// File: tb/tb_cmp_pipe.sv
// tb/tb_cmp_pipe.sv - directed self-checking bench for cmp_pipe
// Drives at the falling edge, samples 1ns later, scores results against a queue of expected beats.
module tb_cmp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [3:0]  sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        compout;
  logic [2:0]  flags;
  logic        sel_err;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [3:0]  sel8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic        compout8;
  logic [2:0]  flags8;
  logic        sel_err8;

  int          checks = 0;
  int          errors = 0;
  int          nout = 0;
  logic [4:0]  expq[$];

  always #5 clk = ~clk;

  cmp_pipe #(.WIDTH(16), .SIGNED_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .compout(compout), .flags(flags), .sel_err(sel_err)
  );

  cmp_pipe #(.WIDTH(8), .SIGNED_EN(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sel(sel8), .out_valid(out_valid8), .out_ready(out_ready8),
    .compout(compout8), .flags(flags8), .sel_err(sel_err8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result {compout, lt_s, lt_u, eq, sel_err} using plain integer arithmetic.
  function automatic logic [4:0] model(input logic [15:0] x, input logic [15:0] y, input logic [3:0] s);
    int ux, uy, sx, sy;
    logic e, lu, ls, l, c, er;
    ux = int'(x);
    uy = int'(y);
    sx = x[15] ? ux - 65536 : ux;
    sy = y[15] ? uy - 65536 : uy;
    e  = (ux == uy);
    lu = (ux < uy);
    ls = (sx < sy);
    l  = s[3] ? ls : lu;
    c  = 1'b0;
    er = 1'b0;
    case (s[2:0])
      3'd0: c = e;
      3'd1: c = !e;
      3'd2: c = (ux != uy) && !l;
      3'd3: c = !l;
      3'd4: c = l;
      3'd5: c = l | e;
      default: er = 1'b1;
    endcase
    return {c, ls, lu, e, er};
  endfunction

  // One cycle: drive, observe pre-edge, score handshakes, advance to the next falling edge.
  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic [3:0] is, input logic ordy, input logic [4:0] ex,
                      output logic acc, output logic rdy, output logic [5:0] obs);
    logic [4:0] e;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    sel       = is;
    out_ready = ordy;
    #1;
    rdy = in_ready;
    obs = {out_valid, compout, flags, sel_err};
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      nout++;
      if (expq.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = expq.pop_front();
        check("result", {compout, flags, sel_err}, e);
      end
    end
    if (acc) expq.push_back(ex);
    @(posedge clk);
    @(negedge clk);
  endtask

  logic        acc, rdy;
  logic [5:0]  obs, snap;
  logic [15:0] va, vb;
  logic [3:0]  vs;
  logic [15:0] vals[8];
  logic [4:0]  sweep_exp[8];
  int          k, n0;

  initial begin
    vals = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001, 16'h1234, 16'h8001, 16'h7FFE};
    sweep_exp = '{5'b1_001_0, 5'b0_001_0, 5'b0_001_0, 5'b1_001_0,
                  5'b0_001_0, 5'b1_001_0, 5'b0_001_1, 5'b0_001_1};

    // reset state
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_outputs", {compout, flags, sel_err}, 5'b0);
    check("rst_in_ready8", in_ready8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    @(negedge clk);

    // 8-bit unsigned-only instance: sel[3] ignored, FF > 01
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; sel8 = 4'b1010;
    @(posedge clk); @(negedge clk);
    in_valid8 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("w8_valid", out_valid8, 1);
    check("w8_compout", compout8, 1);
    check("w8_ltu_eq", flags8 & 3'b011, 3'b000);
    check("w8_sel_err", sel_err8, 0);
    @(negedge clk);

    // signed vs unsigned on 8000/0001, with latency
    step(1, 16'h8000, 16'h0001, 4'b1100, 1, 5'b1_100_0, acc, rdy, obs);
    check("s_accept", acc, 1);
    step(0, 0, 0, 0, 1, 0, acc, rdy, obs);
    check("lat_edge1", obs[5], 0);
    step(0, 0, 0, 0, 1, 0, acc, rdy, obs);
    check("lat_edge2", obs, 6'b1_1_100_0);
    step(1, 16'h8000, 16'h0001, 4'b0100, 1, 5'b0_100_0, acc, rdy, obs);
    step(0, 0, 0, 0, 1, 0, acc, rdy, obs);
    step(0, 0, 0, 0, 1, 0, acc, rdy, obs);
    check("u_out", obs, 6'b1_0_100_0);
    step(0, 0, 0, 0, 1, 0, acc, rdy, obs);

    // sel sweep on equal operands, back to back
    for (int s = 0; s < 8; s++) begin
      step(1, 16'h1234, 16'h1234, 4'(s), 1, sweep_exp[s], acc, rdy, obs);
      check("sweep_throughput", acc, 1);
    end
    for (int c = 0; c < 5; c++) step(0, 0, 0, 0, 1, 0, acc, rdy, obs);
    check("sweep_drained", expq.size(), 0);

    // 8-beat stream with a 5-cycle stall
    k = 0; snap = '0; n0 = nout;
    for (int c = 0; c < 40 && (k < 8 || expq.size() != 0); c++) begin
      va = 16'(k * 16'h1111);
      vb = 16'h4444;
      vs = {k[0], 3'(k % 6)};
      step(k < 8, va, vb, vs, !(c >= 3 && c < 8), model(va, vb, vs), acc, rdy, obs);
      if (acc) k++;
      if (c == 3) snap = obs;
      if (c >= 3 && c < 8) check("stall_in_ready", rdy, 0);
      if (c > 3 && c < 8) check("stall_hold", obs, snap);
    end
    check("stream_beats", k, 8);
    check("stream_outs", nout - n0, 8);
    check("stream_drained", expq.size(), 0);

    // toggling out_ready with in_valid held high
    k = 0; n0 = nout;
    for (int c = 0; c < 100 && (k < 16 || expq.size() != 0); c++) begin
      va = vals[k % 8];
      vb = vals[(k * 3 + 1) % 8];
      vs = 4'(k % 16);
      step(k < 16, va, vb, vs, c[0], model(va, vb, vs), acc, rdy, obs);
      if (acc) k++;
    end
    check("toggle_beats", k, 16);
    check("toggle_outs", nout - n0, 16);
    check("toggle_drained", expq.size(), 0);

    // reset with both stages full
    step(1, 16'h0000, 16'h0000, 4'd1, 0, 5'b0_001_0, acc, rdy, obs);
    step(1, 16'h0000, 16'h0000, 4'd1, 0, 5'b0_001_0, acc, rdy, obs);
    step(0, 0, 0, 0, 0, 0, acc, rdy, obs);
    check("full_before_rst", {obs[5], rdy}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_in_ready", in_ready, 0);
    check("async_outputs", {compout, flags, sel_err}, 5'b0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 16'h0005, 16'h0003, 4'd2, 1, 5'b1_000_0, acc, rdy, obs);
    check("post_rst_accept", acc, 1);
    step(0, 0, 0, 0, 1, 0, acc, rdy, obs);
    step(0, 0, 0, 0, 1, 0, acc, rdy, obs);
    check("post_rst_first", obs, 6'b1_1_000_0);
    step(0, 0, 0, 0, 1, 0, acc, rdy, obs);
    check("post_rst_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
